bitop_sequencer: RTL and testbench
==================================

// Module: bitop_sequencer
// PURPOSE
// Sequenced, programmable version of the 4x16 bitwise register datapath. Holds a small
// program of register ops (MOV/NOT/AND/OR/XOR); on start it loads r0..r3 from a0,a1,b0,b1,
// executes one instruction per clock until HALT, then publishes r3..r0 on y3..y0 with a
// done pulse. Sits between the candidate loader (writes programs) and the fitness evaluator.
// PARAMETERS
// W           16   datapath width of a*/b*/y*/r*
// PROG_DEPTH  16   instruction slots; power of two, >=2
// AW          $clog2(PROG_DEPTH)  program address width (localparam)
// PORTS
// clk        in   1   clock, all logic on rising edge
// rst_n      in   1   synchronous, active-low reset
// prog_we    in   1   program write strobe
// prog_addr  in   AW  program write address
// prog_data  in   8   instruction {op[7:5], dst[4:3], src[2:0]}
// start      in   1   run request, sampled in IDLE only
// a1,a0,b1,b0 in  W   operands, sampled on the accepted start edge
// busy       out  1   state != IDLE
// done       out  1   one-cycle pulse, y* valid from this cycle
// load_err   out  1   one-cycle pulse: prog_we while busy (write dropped)
// y3,y2,y1,y0 out W   results = r3..r0, registered, held until next done
// BEHAVIOUR
// - Reset (rst_n=0 at edge): state IDLE, pc=0, r*=0, y*=0, busy=done=load_err=0, every
//   program slot := 8'h00 (HALT). Reset mid-run aborts immediately; no done pulse.
// - Opcodes: 0 HALT, 1 MOV d=s, 2 LNOT d=(s==0)?1:0 (zero-extended), 3 BNOT d=~s,
//   4 AND d&=s, 5 OR d|=s, 6 XOR d^=s, 7 NOP. dst selects r0..r3.
//   src 0..3 = r0..r3 (current value), 4..7 = a0,a1,b0,b1 as latched at start.
// - FSM IDLE -> EXEC -> DONE -> IDLE.
//   IDLE: start=1 at edge => r0=a0,r1=a1,r2=b0,r3=b1, latch inputs, pc=0, go EXEC.
//   EXEC: execute mem[pc]; non-HALT writes r[dst], pc++. HALT writes nothing -> DONE.
//         Non-HALT at pc=PROG_DEPTH-1 executes then -> DONE (pc does not wrap).
//   DONE: y3..y0 = r3..r0 registered this edge-visible cycle; done=1 for exactly this
//         cycle; -> IDLE next edge.
// - Latency: K ops before HALT at pc=K => done high K+2 cycles after start edge.
//   Empty program (mem[0]=HALT) => done 2 cycles after start. No HALT => PROG_DEPTH+1.
// - One op per cycle; read-after-write between consecutive ops sees the updated register.
// - start while busy: ignored (no queueing). start held high: new run begins the cycle
//   after DONE returns to IDLE.
// - prog_we in IDLE: mem[prog_addr]=prog_data at edge. prog_we and start same IDLE edge:
//   write lands first; run uses new contents. prog_we while busy: dropped, load_err=1.
// - a*/b* changes during a run have no effect (latched copy used for src 4..7).
// STRUCTURE
// - Package bitop_seq_pkg: op_e enum (3b), instr_t packed struct {op,dst,src},
//   state_e enum {IDLE,EXEC,DONE}, OP_HALT/OP_NOP constants.
// - Sub-module bitop_alu: purely combinational, (op, dst_val, src_val) -> {wr_en, result}.
// - Top holds program array, r0..r3, latched inputs, pc, FSM, output registers.
// TESTING
// - Reset then start, a0=1,a1=3,b0=5,b1=7, program untouched -> done at +2, y3..y0=7,5,3,1.
// - Prog {LNOT r3,r2; XOR r0,r1; AND r2,b1; AND r0,a1; HALT}, a0=00F0,a1=0FF0,b0=FF00,
//   b1=F0F0 -> done at +6, y3=0000,y2=F000,y1=0FF0,y0=0F00.
// - All 16 slots MOV r0,r0 (no HALT) -> done exactly 17 cycles after start, y=inputs.
// - prog_we during run -> load_err pulse, slot unchanged on readback-by-execution;
//   start during run ignored, single done.
// - Reset asserted at EXEC cycle 3 -> no done, y*=0, busy=0, program reverted to HALT.
// - prog_we(addr0,MOV r1,b1) same edge as start -> y1=b1 in result.

Source files
------------

// File: rtl/bitop_seq_pkg.sv
// Shared types for the bitop sequencer: opcodes, instruction layout and FSM states.
package bitop_seq_pkg;

    typedef enum logic [2:0] {
        OP_HALT = 3'd0,
        OP_MOV  = 3'd1,
        OP_LNOT = 3'd2,
        OP_BNOT = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_XOR  = 3'd6,
        OP_NOP  = 3'd7
    } op_e;

    // src 0..3 = r0..r3, src 4..7 = a0,a1,b0,b1 as latched at start
    typedef struct packed {
        op_e        op;
        logic [1:0] dst;
        logic [2:0] src;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bitop_alu.sv
// Combinational op unit: computes the new destination value and whether it is written.
module bitop_alu
    import bitop_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  op_e          op,
    input  logic [W-1:0] dst_val,
    input  logic [W-1:0] src_val,
    output logic         wr_en,
    output logic [W-1:0] result
);

    always_comb begin
        wr_en  = 1'b1;
        result = dst_val;
        case (op)
            OP_MOV:  result = src_val;
            OP_LNOT: result = {{(W-1){1'b0}}, ~|src_val};
            OP_BNOT: result = ~src_val;
            OP_AND:  result = dst_val & src_val;
            OP_OR:   result = dst_val | src_val;
            OP_XOR:  result = dst_val ^ src_val;
            default: wr_en  = 1'b0;
        endcase
    end

endmodule

// File: rtl/bitop_sequencer.sv
// Programmable 4x16 register datapath: runs the stored op list on start and
// publishes r3..r0 with a one-cycle done pulse.
//
// state | meaning
// IDLE  | accepts program writes and start
// EXEC  | executes mem[pc], one op per clock
// DONE  | final registers captured into y*, done pulses next cycle
module bitop_sequencer
    import bitop_seq_pkg::*;
#(
    parameter int W          = 16,
    parameter int PROG_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [7:0]                    prog_data,
    input  logic                          start,
    input  logic [W-1:0]                  a1,
    input  logic [W-1:0]                  a0,
    input  logic [W-1:0]                  b1,
    input  logic [W-1:0]                  b0,
    output logic                          busy,
    output logic                          done,
    output logic                          load_err,
    output logic [W-1:0]                  y3,
    output logic [W-1:0]                  y2,
    output logic [W-1:0]                  y1,
    output logic [W-1:0]                  y0
);

    localparam int AW = $clog2(PROG_DEPTH);

    instr_t        mem [PROG_DEPTH];
    state_e        state, state_nxt;
    logic [AW-1:0] pc;
    logic [W-1:0]  r   [4];
    logic [W-1:0]  inl [4];
    instr_t        cur;
    logic [W-1:0]  src_val;
    logic [W-1:0]  alu_res;
    logic          alu_we;
    logic          last_slot;

    assign cur       = mem[pc];
    assign src_val   = cur.src[2] ? inl[cur.src[1:0]] : r[cur.src[1:0]];
    assign last_slot = (pc == AW'(PROG_DEPTH - 1));
    assign busy      = (state != IDLE);

    bitop_alu #(.W(W)) u_alu (
        .op      (cur.op),
        .dst_val (r[cur.dst]),
        .src_val (src_val),
        .wr_en   (alu_we),
        .result  (alu_res)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = EXEC;
            EXEC:    if (cur.op == OP_HALT || last_slot) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= '0;
            done     <= 1'b0;
            load_err <= 1'b0;
            y3       <= '0;
            y2       <= '0;
            y1       <= '0;
            y0       <= '0;
            for (int i = 0; i < 4; i++) begin
                r[i]   <= '0;
                inl[i] <= '0;
            end
            for (int i = 0; i < PROG_DEPTH; i++) mem[i] <= '0;
        end else begin
            done     <= (state == DONE);
            load_err <= prog_we && (state != IDLE);
            // write lands before a same-edge start's first fetch
            if (prog_we && state == IDLE) mem[prog_addr] <= instr_t'(prog_data);
            case (state)
                IDLE: if (start) begin
                    r[0]   <= a0;
                    r[1]   <= a1;
                    r[2]   <= b0;
                    r[3]   <= b1;
                    inl[0] <= a0;
                    inl[1] <= a1;
                    inl[2] <= b0;
                    inl[3] <= b1;
                    pc     <= '0;
                end
                EXEC: begin
                    if (alu_we) r[cur.dst] <= alu_res;
                    if (cur.op != OP_HALT && !last_slot) pc <= pc + 1'b1;
                end
                DONE: begin
                    y3 <= r[3];
                    y2 <= r[2];
                    y1 <= r[1];
                    y0 <= r[0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bitop_sequencer.sv
// Self-checking bench for bitop_sequencer against a behavioural program interpreter.
module tb_bitop_sequencer;

    localparam int W  = 16;
    localparam int PD = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n, prog_we, start;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_data;
    logic [W-1:0]  a0, a1, b0, b1;
    logic          busy, done, load_err;
    logic [W-1:0]  y0, y1, y2, y3;

    int errors = 0;
    int checks = 0;

    logic [7:0] mdl_mem [PD];
    logic [W-1:0] exp_y [4];
    int exp_lat;

    bitop_sequencer #(.W(W), .PROG_DEPTH(PD)) dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .a1(a1), .a0(a0), .b1(b1), .b0(b0),
        .busy(busy), .done(done), .load_err(load_err),
        .y3(y3), .y2(y2), .y1(y1), .y0(y0)
    );

    always #5 clk = ~clk;

    // Interpret the stored program directly from the instruction semantics.
    function automatic void model(input logic [W-1:0] i0, i1, i2, i3);
        logic [W-1:0] rr [4];
        logic [W-1:0] inp [4];
        logic [W-1:0] v;
        int op, d, s;
        rr[0] = i0; rr[1] = i1; rr[2] = i2; rr[3] = i3;
        inp[0] = i0; inp[1] = i1; inp[2] = i2; inp[3] = i3;
        exp_lat = PD + 1;
        for (int p = 0; p < PD; p++) begin
            op = int'(mdl_mem[p][7:5]);
            d  = int'(mdl_mem[p][4:3]);
            s  = int'(mdl_mem[p][2:0]);
            if (op == 0) begin
                exp_lat = p + 2;
                break;
            end
            v = (s < 4) ? rr[s] : inp[s-4];
            case (op)
                1: rr[d] = v;
                2: rr[d] = (v == 0) ? 1 : 0;
                3: rr[d] = ~v;
                4: rr[d] = rr[d] & v;
                5: rr[d] = rr[d] | v;
                6: rr[d] = rr[d] ^ v;
                default: ;
            endcase
        end
        for (int k = 0; k < 4; k++) exp_y[k] = rr[k];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_slot(input int addr, input logic [7:0] data);
        prog_we   = 1'b1;
        prog_addr = addr[AW-1:0];
        prog_data = data;
        tick();
        prog_we = 1'b0;
        mdl_mem[addr] = data;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < PD; i++) mdl_mem[i] = 8'h00;
    endtask

    task automatic run_and_check(input string name, input logic [W-1:0] i0, i1, i2, i3);
        int lat;
        model(i0, i1, i2, i3);
        a0 = i0; a1 = i1; b0 = i2; b1 = i3;
        start = 1'b1;
        tick();
        start = 1'b0;
        prog_we = 1'b0;
        a0 = W'($urandom); a1 = W'($urandom); b0 = W'($urandom); b1 = W'($urandom);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_in_run: got %b expected 1", name, busy);
                end
            end
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d (-1 = no done)", name, lat, exp_lat);
        end
        checks++;
        if ({y3, y2, y1, y0} !== {exp_y[3], exp_y[2], exp_y[1], exp_y[0]}) begin
            errors++;
            $display("FAIL %s y3..y0: got %h %h %h %h expected %h %h %h %h", name,
                     y3, y2, y1, y0, exp_y[3], exp_y[2], exp_y[1], exp_y[0]);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        prog_we = 0; start = 0; prog_addr = '0; prog_data = '0;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0;
        do_reset();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b done=%b load_err=%b expected 0 0 0",
                     busy, done, load_err);
        end
        checks++;
        if ({y3, y2, y1, y0} !== '0) begin
            errors++;
            $display("FAIL reset_y: got %h %h %h %h expected 0", y3, y2, y1, y0);
        end
    endtask

    task automatic test_default();
        run_and_check("default", 16'd1, 16'd3, 16'd5, 16'd7);
    endtask

    task automatic test_spec_prog();
        write_slot(0, 8'h5A);
        write_slot(1, 8'hC1);
        write_slot(2, 8'h97);
        write_slot(3, 8'h85);
        write_slot(4, 8'h00);
        run_and_check("spec_prog", 16'h00F0, 16'h0FF0, 16'hFF00, 16'hF0F0);
    endtask

    task automatic test_no_halt();
        for (int i = 0; i < PD; i++) write_slot(i, 8'h20);
        run_and_check("no_halt", W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < PD; i++) write_slot(i, 8'($urandom));
            if (it % 2 == 0) write_slot($urandom_range(2, PD - 1), 8'h00);
            run_and_check($sformatf("random%0d", it),
                          W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        end
    endtask

    task automatic test_busy();
        int ndone, first;
        for (int i = 0; i < 8; i++) write_slot(i, {3'($urandom_range(1, 7)), 5'($urandom)});
        write_slot(8, 8'h00);
        model(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        a0 = 16'h1234; a1 = 16'h5678; b0 = 16'h9ABC; b1 = 16'hDEF0;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        first = -1;
        for (int n = 1; n <= 30; n++) begin
            if (n == 2) begin
                prog_we = 1'b1; prog_addr = '0; prog_data = 8'h00;
            end
            if (n == 3) begin
                prog_we = 1'b0; start = 1'b1;
            end
            if (n == 4) start = 1'b0;
            tick();
            if (n == 2) begin
                checks++;
                if (load_err !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_load_err: got %b expected 1", load_err);
                end
            end
            if (n == 3) begin
                checks++;
                if (load_err !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_load_err_pulse: got %b expected 0", load_err);
                end
            end
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) begin
                    first = n;
                    checks++;
                    if ({y3, y2, y1, y0} !== {exp_y[3], exp_y[2], exp_y[1], exp_y[0]}) begin
                        errors++;
                        $display("FAIL busy_y: got %h %h %h %h expected %h %h %h %h",
                                 y3, y2, y1, y0, exp_y[3], exp_y[2], exp_y[1], exp_y[0]);
                    end
                end
            end
        end
        checks++;
        if (ndone !== 1 || first !== exp_lat) begin
            errors++;
            $display("FAIL busy_single_done: got count=%0d at=%0d expected count=1 at=%0d",
                     ndone, first, exp_lat);
        end
        run_and_check("busy_rerun", W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    endtask

    task automatic test_reset_midrun();
        int seen;
        seen = 0;
        a0 = W'($urandom); a1 = W'($urandom); b0 = W'($urandom); b1 = W'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        rst_n = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_abort: got done_count=%0d busy=%b expected 0 0", seen, busy);
        end
        checks++;
        if ({y3, y2, y1, y0} !== '0) begin
            errors++;
            $display("FAIL midrun_y: got %h %h %h %h expected 0", y3, y2, y1, y0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < PD; i++) mdl_mem[i] = 8'h00;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL midrun_late_done: got %b expected 0", done);
            end
        end
        run_and_check("post_reset", W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    endtask

    task automatic test_same_edge();
        prog_we   = 1'b1;
        prog_addr = '0;
        prog_data = 8'h2F;
        mdl_mem[0] = 8'h2F;
        run_and_check("same_edge", W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    endtask

    task automatic test_back_to_back();
        int first, second, prev;
        first = -1; second = -1; prev = 0;
        model(16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0);
        a0 = 16'hAAAA; a1 = 16'h5555; b0 = 16'h0F0F; b1 = 16'hF0F0;
        start = 1'b1;
        tick();
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (done === 1'b1 && prev == 0) begin
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
            prev = (done === 1'b1) ? 1 : 0;
        end
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        checks++;
        // next run is accepted the cycle after DONE returns to IDLE
        if (first !== exp_lat || second !== 2 * exp_lat + 1) begin
            errors++;
            $display("FAIL back_to_back: got done at %0d,%0d expected %0d,%0d",
                     first, second, exp_lat, 2 * exp_lat + 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_default();
        test_spec_prog();
        test_no_halt();
        test_random();
        test_busy();
        test_reset_midrun();
        test_same_edge();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
